// File: rtl/iter_mag_comparator_pkg.sv
// Shared constants for the iterative magnitude comparator: result encoding
// (same as the 4-bit combinational comparator) and FSM state encodings.
package iter_mag_comparator_pkg;

  localparam logic [1:0] CMP_LT = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_EQ = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index register width; a single-slice configuration still needs one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/iter_mag_comparator_slice_cmp.sv
// Combinational unsigned comparator for one SLICE-bit slice.
module iter_mag_comparator_slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/iter_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator: scans SLICE bits per cycle from
// the MSB slice down and stops at the first differing slice.
module iter_mag_comparator
  import iter_mag_comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       result,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid only in DONE, where result is
  // held until out_ready is seen.

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [1:0]       result_q, result_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [SLICE-1:0] sl_a, sl_b;
  logic             sl_gt, sl_lt, sl_eq;

  // Flipping both sign bits maps two's-complement order onto unsigned order;
  // only the top slice ever sees the sign bit.
  always_comb begin
    op_a = a_q;
    op_b = b_q;
    if (signed_q && (idx_q == IDX_TOP)) begin
      op_a = a_q ^ MSB_MASK;
      op_b = b_q ^ MSB_MASK;
    end
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        sl_a = op_a[i*SLICE +: SLICE];
        sl_b = op_b[i*SLICE +: SLICE];
      end
    end
  end

  iter_mag_comparator_slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .a_i  (sl_a),
    .b_i  (sl_b),
    .gt_o (sl_gt),
    .lt_o (sl_lt),
    .eq_o (sl_eq)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          idx_d    = IDX_TOP;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (sl_gt) begin
          result_d = CMP_GT;
          state_d  = ST_DONE;
        end else if (sl_lt) begin
          result_d = CMP_LT;
          state_d  = ST_DONE;
        end else if (sl_eq && (idx_q == '0)) begin
          result_d = CMP_EQ;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_TOP;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      result_q <= CMP_LT;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_iter_mag_comparator.sv
// Bench for iter_mag_comparator: directed vector table on a 32/4 instance,
// hand-written back-pressure and reset sequences, and a sweep on 8/1, 16/16, 64/8.
module tb_iter_mag_comparator;
  import iter_mag_comparator_pkg::*;

  logic clk;
  logic rst_n;

  // 32/4 instance
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [1:0]  result;

  // sweep instances
  logic        s1_iv, s1_ir, s1_sm, s1_ov, s1_or, s1_busy;
  logic [7:0]  s1_a, s1_b;
  logic [1:0]  s1_res;
  logic        s2_iv, s2_ir, s2_sm, s2_ov, s2_or, s2_busy;
  logic [15:0] s2_a, s2_b;
  logic [1:0]  s2_res;
  logic        s3_iv, s3_ir, s3_sm, s3_ov, s3_or, s3_busy;
  logic [63:0] s3_a, s3_b;
  logic [1:0]  s3_res;

  int total_cnt = 0;
  int pass_cnt  = 0;

  iter_mag_comparator #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );
  iter_mag_comparator #(.WIDTH(8), .SLICE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_iv), .in_ready(s1_ir),
    .a(s1_a), .b(s1_b), .signed_mode(s1_sm), .out_valid(s1_ov),
    .out_ready(s1_or), .result(s1_res), .busy(s1_busy)
  );
  iter_mag_comparator #(.WIDTH(16), .SLICE(16)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s2_iv), .in_ready(s2_ir),
    .a(s2_a), .b(s2_b), .signed_mode(s2_sm), .out_valid(s2_ov),
    .out_ready(s2_or), .result(s2_res), .busy(s2_busy)
  );
  iter_mag_comparator #(.WIDTH(64), .SLICE(8)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(s3_iv), .in_ready(s3_ir),
    .a(s3_a), .b(s3_b), .signed_mode(s3_sm), .out_valid(s3_ov),
    .out_ready(s3_or), .result(s3_res), .busy(s3_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One full transaction on the 32/4 instance; called #1 after an edge while idle.
  task automatic run_main(input logic [31:0] ta, input logic [31:0] tb_v, input logic sm,
                          input logic [1:0] er, input int el, input string nm);
    int   lat;
    logic hs_ok;
    check({nm, " ready"}, in_ready, 1'b1);
    a = ta; b = tb_v; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; signed_mode = ~sm;
    lat = 0;
    hs_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'(el));
    check({nm, " result"}, result, er);
    check({nm, " busy_no_ready"}, hs_ok, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, " drained"}, out_valid, 1'b0);
  endtask

  function automatic logic get_ov(input int cfg);
    case (cfg)
      0:       return s1_ov;
      1:       return s2_ov;
      default: return s3_ov;
    endcase
  endfunction

  function automatic logic [1:0] get_res(input int cfg);
    case (cfg)
      0:       return s1_res;
      1:       return s2_res;
      default: return s3_res;
    endcase
  endfunction

  // Sweep transaction with a full-width reference compare.
  task automatic run_sweep(input int cfg, input logic [63:0] ra, input logic [63:0] rb,
                           input logic sm);
    int w, s, ns, lat, k;
    logic [63:0] mask, am, bm, ae, be, x;
    logic [1:0] er;
    w  = (cfg == 0) ? 8 : (cfg == 1) ? 16 : 64;
    s  = (cfg == 0) ? 1 : (cfg == 1) ? 16 : 8;
    ns = w / s;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am = ra & mask;
    bm = rb & mask;
    if (am == bm) er = CMP_EQ;
    else if (sm) begin
      ae = am[w-1] ? (am | ~mask) : am;
      be = bm[w-1] ? (bm | ~mask) : bm;
      er = ($signed(ae) > $signed(be)) ? CMP_GT : CMP_LT;
    end else begin
      er = (am > bm) ? CMP_GT : CMP_LT;
    end
    x = am ^ bm;
    k = ns;
    for (int p = 0; p < w; p++) if (x[p]) k = ns - p / s;
    case (cfg)
      0: begin s1_a = am[7:0];  s1_b = bm[7:0];  s1_sm = sm; s1_iv = 1'b1; end
      1: begin s2_a = am[15:0]; s2_b = bm[15:0]; s2_sm = sm; s2_iv = 1'b1; end
      default: begin s3_a = am; s3_b = bm; s3_sm = sm; s3_iv = 1'b1; end
    endcase
    @(posedge clk); #1;
    s1_iv = 1'b0; s2_iv = 1'b0; s3_iv = 1'b0;
    lat = 0;
    while (!get_ov(cfg) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("sweep%0d latency a=%0h b=%0h sm=%0d", cfg, am, bm, sm), 64'(lat), 64'(k));
    check($sformatf("sweep%0d result a=%0h b=%0h sm=%0d", cfg, am, bm, sm), get_res(cfg), er);
    s1_or = (cfg == 0); s2_or = (cfg == 1); s3_or = (cfg == 2);
    @(posedge clk); #1;
    s1_or = 1'b0; s2_or = 1'b0; s3_or = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [1:0]  res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    logic [63:0] ra, rb;
    int w, sel;

    vecs[0]  = '{32'hF0000000, 32'h0FFFFFFF, 1'b0, CMP_GT, 1};
    vecs[1]  = '{32'h00000001, 32'h00000002, 1'b0, CMP_LT, 8};
    vecs[2]  = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, CMP_EQ, 8};
    vecs[3]  = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, CMP_EQ, 8};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, CMP_LT, 1};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, CMP_GT, 1};
    vecs[6]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, CMP_LT, 1};
    vecs[7]  = '{32'h12345678, 32'h12345679, 1'b1, CMP_LT, 8};
    vecs[8]  = '{32'h00F00000, 32'h00E00000, 1'b0, CMP_GT, 3};
    vecs[9]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, CMP_LT, 8};
    vecs[10] = '{32'h80000000, 32'h80000001, 1'b1, CMP_LT, 8};
    vecs[11] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, CMP_LT, 1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    s1_iv = 1'b0; s1_or = 1'b0; s1_a = '0; s1_b = '0; s1_sm = 1'b0;
    s2_iv = 1'b0; s2_or = 1'b0; s2_a = '0; s2_b = '0; s2_sm = 1'b0;
    s3_iv = 1'b0; s3_or = 1'b0; s3_a = '0; s3_b = '0; s3_sm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, CMP_LT);
    check("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_main(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res, vecs[i].lat,
               $sformatf("vec%0d", i));

    // back-pressure: result held in DONE, new operands wait for IDLE
    a = 32'd5; b = 32'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 64'(lat), 64'd8);
    check("bp result", result, CMP_GT);
    a = 32'd1; b = 32'd2; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp hold out_valid", out_valid, 1'b1);
      check("bp hold result", result, CMP_GT);
      check("bp hold in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", out_valid, 1'b0);
    check("bp release in_ready", in_ready, 1'b1);
    check("bp release result kept", result, CMP_GT);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp pending accepted", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp pending latency", 64'(lat), 64'd8);
    check("bp pending result", result, CMP_LT);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset at edge 3 of an 8-slice compare
    run_main(32'h90000000, 32'h10000000, 1'b0, CMP_GT, 1, "pre_rst");
    a = 32'hDEADBEEF; b = 32'hDEADBEEF; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst in_ready", in_ready, 1'b1);
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst result", result, CMP_LT);
    check("midrst busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst no result", out_valid, 1'b0);
    run_main(32'h00000020, 32'h00000010, 1'b1, CMP_GT, 7, "post_rst");

    // parameter sweep
    for (int cfg = 0; cfg < 3; cfg++) begin
      w = (cfg == 0) ? 8 : (cfg == 1) ? 16 : 64;
      for (int n = 0; n < 300; n++) begin
        ra = {$urandom, $urandom};
        sel = $urandom_range(0, 3);
        if (sel == 0) rb = ra;
        else if (sel == 1) rb = ra ^ (64'd1 << $urandom_range(0, w - 1));
        else rb = {$urandom, $urandom};
        run_sweep(cfg, ra, rb, 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
